// File: rtl/switch_debounce_select.sv
//------------------------------------------------------------------------------
// switch_debounce_select
//
// Conditions the raw board inputs that feed the LED blink-frequency stage. The
// inputs are two frequency-select switches and one enable push button. Each
// input passes through a two-flop synchroniser and then a stable-level
// debouncer. The block also produces a one-cycle pulse whenever the debounced
// frequency selection changes.
//
// Parameters:
//   DEBOUNCE_LIMIT  consecutive stable cycles needed to accept a new level
//                   (250 = 10 ms at 25 kHz); legal range 2..65535
//   COUNT_WIDTH     debounce counter width; 2**COUNT_WIDTH > DEBOUNCE_LIMIT
//
// Ports:
//   i_clock          25 kHz system clock; all logic runs on the rising edge
//   i_reset          synchronous, active-high reset
//   i_switch_1       raw asynchronous switch 1 (select MSB)
//   i_switch_2       raw asynchronous switch 2 (select LSB)
//   i_button         raw asynchronous enable button, high = pressed
//   o_switch_1       debounced switch 1
//   o_switch_2       debounced switch 2
//   o_enable         enable for the blink stage
//   o_select_change  one-cycle pulse after {o_switch_1,o_switch_2} changes
//
// Build option:
//   BUTTON_TOGGLE_EN  when defined, each debounced button press toggles
//                     o_enable. When undefined, o_enable follows the
//                     debounced button level, so the LEDs run only while the
//                     button is held.
//------------------------------------------------------------------------------
module switch_debounce_select #(
    parameter int DEBOUNCE_LIMIT = 250,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_switch_1,
    input  logic i_switch_2,
    input  logic i_button,
    output logic o_switch_1,
    output logic o_switch_2,
    output logic o_enable,
    output logic o_select_change
);

    // Channel indices: 0 = switch_1, 1 = switch_2, 2 = button.
    localparam int NUM_CH = 3;
    localparam int CH_SW1 = 0;
    localparam int CH_SW2 = 1;
    localparam int CH_BTN = 2;

    // The terminal count. Reaching it with the input still differing from stb
    // means the new level has been held for DEBOUNCE_LIMIT cycles.
    localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(DEBOUNCE_LIMIT - 1);

    logic [NUM_CH-1:0]      raw_in;
    logic [NUM_CH-1:0]      sync1;
    logic [NUM_CH-1:0]      sync2;
    logic [NUM_CH-1:0]      stb;
    logic [COUNT_WIDTH-1:0] cnt [NUM_CH];

    logic [1:0] prev_sel;
    logic [1:0] cur_sel;
    logic       sel_change;
    logic       btn_stb_d;
    logic       btn_rise;

    assign raw_in  = {i_button, i_switch_2, i_switch_1};
    assign cur_sel = {stb[CH_SW1], stb[CH_SW2]};

    // The button press edge: stb is 1 now and was 0 one cycle ago.
    assign btn_rise = stb[CH_BTN] & ~btn_stb_d;

    // Synchronisers, debounce counters and stable registers.
    // NOTE: sequential state uses non-blocking (<=) assignments only. Every
    // register then samples pre-edge values, which is what keeps sync1 ->
    // sync2 -> stb a true pipeline.
    always_ff @(posedge i_clock) begin
        // NOTE: the counters are ordinary flops rather than a RAM, so they can
        // be cleared by the same synchronous reset as the rest of the state.
        // A reset in mid-count therefore discards the partial count.
        if (i_reset) begin
            sync1 <= '0;
            sync2 <= '0;
            stb   <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt[ch] <= '0;
            end
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (sync2[ch] != stb[ch]) begin
                    if (cnt[ch] == CNT_LAST) begin
                        stb[ch] <= sync2[ch];
                        cnt[ch] <= '0;
                    end else begin
                        cnt[ch] <= cnt[ch] + 1'b1;
                    end
                end else begin
                    // The input agrees with stb, so any glitch restarts the
                    // count. The counter therefore never passes CNT_LAST.
                    cnt[ch] <= '0;
                end
            end
        end
    end

    // Selection-change pulse and the button edge register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            prev_sel   <= '0;
            sel_change <= 1'b0;
            btn_stb_d  <= 1'b0;
        end else begin
            prev_sel   <= cur_sel;
            sel_change <= (prev_sel != cur_sel);
            btn_stb_d  <= stb[CH_BTN];
        end
    end

`ifdef BUTTON_TOGGLE_EN
    logic enable_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            enable_q <= 1'b0;
        end else if (btn_rise) begin
            enable_q <= ~enable_q;
        end
    end

    assign o_enable = enable_q;
`else
    // The edge register stays in the design in this build, but nothing uses it.
    logic unused_btn_rise;
    assign unused_btn_rise = btn_rise;

    assign o_enable = stb[CH_BTN];
`endif

    assign o_switch_1      = stb[CH_SW1];
    assign o_switch_2      = stb[CH_SW2];
    assign o_select_change = sel_change;

endmodule

// File: tb/tb_switch_debounce_select.sv
//------------------------------------------------------------------------------
// tb_switch_debounce_select
//
// Bench for switch_debounce_select, built with DEBOUNCE_LIMIT = 4.
//
// The first part is a vector table. It covers the reset state and the first
// acceptance of inputs that are already high. The remaining parts are
// hand-written sequences:
//   - glitch rejection
//   - simultaneous change of both switches
//   - bounce followed by a settled level
//   - button presses
//   - reset asserted in the middle of a count
//------------------------------------------------------------------------------
module tb_switch_debounce_select;

    localparam int LIMIT = 4;
    // The edge (counted from 1 after a raw change) at which stb takes the level.
    localparam int RISE_EDGE = LIMIT + 2;

    logic i_clock = 1'b0;
    logic i_reset;
    logic i_switch_1;
    logic i_switch_2;
    logic i_button;
    logic o_switch_1;
    logic o_switch_2;
    logic o_enable;
    logic o_select_change;

    int checks = 0;
    int errors = 0;

    switch_debounce_select #(
        .DEBOUNCE_LIMIT(LIMIT),
        .COUNT_WIDTH   (16)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_switch_1     (i_switch_1),
        .i_switch_2     (i_switch_2),
        .i_button       (i_button),
        .o_switch_1     (o_switch_1),
        .o_switch_2     (o_switch_2),
        .o_enable       (o_enable),
        .o_select_change(o_select_change)
    );

    always #5 i_clock = ~i_clock;

    // Each vector holds the inputs that are applied before one rising edge,
    // together with the outputs expected just after that edge.
    typedef struct {
        logic rst;
        logic sw1;
        logic sw2;
        logic btn;
        logic e_sw1;
        logic e_sw2;
        logic e_en;
        logic e_chg;
    } vec_t;

`ifdef BUTTON_TOGGLE_EN
    localparam logic TOGGLE = 1'b1;
`else
    localparam logic TOGGLE = 1'b0;
`endif

    task automatic check(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_outs(input string name, input logic e_sw1, input logic e_sw2,
                              input logic e_en, input logic e_chg);
        check({name, ".o_switch_1"}, o_switch_1, e_sw1);
        check({name, ".o_switch_2"}, o_switch_2, e_sw2);
        check({name, ".o_enable"}, o_enable, e_en);
        check({name, ".o_select_change"}, o_select_change, e_chg);
    endtask

    // One rising edge, then settle 1 time unit so outputs are sampled away
    // from the edge.
    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    // Brings the DUT to a clean all-zero state with every raw input low.
    task automatic clean_reset();
        i_reset    = 1'b1;
        i_switch_1 = 1'b0;
        i_switch_2 = 1'b0;
        i_button   = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
        tick();
    endtask

    vec_t vecs[11];

    initial begin
        int rise_at;
        int pulses;
        logic exp_en;
        logic stb_model;
        int toggles;

        i_reset    = 1'b1;
        i_switch_1 = 1'b1;
        i_switch_2 = 1'b1;
        i_button   = 1'b1;

        // Reset is held for 3 edges with all inputs high. Reset is then
        // released, and the first unreset edge (row 3) captures the inputs.
        // stb takes the new level after the sixth unreset edge (row 8). The
        // select pulse follows one edge later, and the toggle build flips
        // enable one edge after button stb rises.
        vecs[0]  = '{1, 1, 1, 1,  0, 0, 0, 0};
        vecs[1]  = '{1, 1, 1, 1,  0, 0, 0, 0};
        vecs[2]  = '{1, 1, 1, 1,  0, 0, 0, 0};
        vecs[3]  = '{0, 1, 1, 1,  0, 0, 0, 0};
        vecs[4]  = '{0, 1, 1, 1,  0, 0, 0, 0};
        vecs[5]  = '{0, 1, 1, 1,  0, 0, 0, 0};
        vecs[6]  = '{0, 1, 1, 1,  0, 0, 0, 0};
        vecs[7]  = '{0, 1, 1, 1,  0, 0, 0, 0};
        vecs[8]  = '{0, 1, 1, 1,  1, 1, !TOGGLE, 0};
        vecs[9]  = '{0, 1, 1, 1,  1, 1, 1, 1};
        vecs[10] = '{0, 1, 1, 1,  1, 1, 1, 0};

        for (int i = 0; i < 11; i++) begin
            i_reset    = vecs[i].rst;
            i_switch_1 = vecs[i].sw1;
            i_switch_2 = vecs[i].sw2;
            i_button   = vecs[i].btn;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_sw1, vecs[i].e_sw2,
                       vecs[i].e_en, vecs[i].e_chg);
        end

        // Glitch: switch 2 is high for 3 cycles only, so no output may move.
        clean_reset();
        i_switch_2 = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        i_switch_2 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("glitch.o_switch_2", o_switch_2, 1'b0);
            check("glitch.o_select_change", o_select_change, 1'b0);
        end

        // Simultaneous change: both outputs rise together, giving a single pulse.
        clean_reset();
        i_switch_1 = 1'b1;
        i_switch_2 = 1'b1;
        rise_at = 0;
        pulses  = 0;
        for (int k = 1; k <= RISE_EDGE + 6; k++) begin
            tick();
            check("simul.sw_equal", o_switch_2, o_switch_1 === 1'b1 ? 1'b1 : 1'b0);
            if (o_switch_1 === 1'b1 && rise_at == 0) rise_at = k;
            if (o_select_change === 1'b1) pulses++;
        end
        check("simul.rise_edge_ok", rise_at == RISE_EDGE, 1'b1);
        check("simul.one_pulse", pulses == 1, 1'b1);

        // Bounce: switch 1 toggles every 2 cycles for 20 cycles and then holds 1.
        clean_reset();
        for (int i = 0; i < 20; i++) begin
            i_switch_1 = ((i / 2) % 2 == 0);
            tick();
            check("bounce.o_switch_1", o_switch_1, 1'b0);
        end
        i_switch_1 = 1'b1;
        for (int k = 1; k <= RISE_EDGE; k++) begin
            tick();
            check($sformatf("settle.e%0d", k), o_switch_1, k == RISE_EDGE);
        end

        // Button: three 10-cycle presses, each followed by 10 low cycles.
        // stb_model is the expected debounced level. In the toggle build,
        // enable flips one edge after stb rises.
        clean_reset();
        toggles = 0;
        for (int p = 0; p < 3; p++) begin
            for (int j = 1; j <= 20; j++) begin
                i_button = (j <= 10);
                tick();
                stb_model = (j >= RISE_EDGE) && (j < 10 + RISE_EDGE);
                if (TOGGLE && j == RISE_EDGE + 1) toggles++;
                exp_en = TOGGLE ? toggles[0] : stb_model;
                check($sformatf("button.p%0d.j%0d", p, j), o_enable, exp_en);
                check("button.o_select_change", o_select_change, 1'b0);
            end
        end

        // Reset mid-count: switch 1 has a pending rise with cnt at 2.
        clean_reset();
        i_switch_1 = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        i_reset = 1'b1;
        tick();
        check_outs("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("midreset.cnt", dut.cnt[0] == 16'd0, 1'b1);
        i_reset = 1'b0;
        for (int k = 1; k <= RISE_EDGE; k++) begin
            tick();
            check($sformatf("midreset.e%0d", k), o_switch_1, k == RISE_EDGE);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
